// File: rtl/ga_sampler_pkg.sv
// Shared definitions for the geographical-address sampler: FSM encoding,
// slot code constants and the GA/GAP parity helpers.
package ga_sampler_pkg;

    localparam logic [4:0] GA_NO_SLOT  = 5'h1F;
    localparam logic [4:0] GA_MIN_SLOT = 5'h0A;
    localparam logic [4:0] GA_MAX_SLOT = 5'h1E;

    localparam logic [2:0] ST_SETTLE = 3'd0;
    localparam logic [2:0] ST_CHECK  = 3'd1;
    localparam logic [2:0] ST_LOCKED = 3'd2;
    localparam logic [2:0] ST_NOSLOT = 3'd3;
    localparam logic [2:0] ST_FAULT  = 3'd4;

    // Backplane GA/GAP is odd parity across all six lines.
    function automatic logic parity_ok(input logic [5:0] vec);
        return ^vec;
    endfunction

    function automatic logic in_slot_range(input logic [4:0] ga);
        return (ga >= GA_MIN_SLOT) && (ga <= GA_MAX_SLOT);
    endfunction

endpackage

// File: rtl/ga_sampler_if.sv
// Signal bundle between the backplane/host side (master) and the GA sampler (slave).
interface ga_sampler_if;

    logic [4:0] GA_IN;
    logic       GAP_IN;
    logic       REACQ;
    logic [4:0] GA_OUT;
    logic       GA_VALID;
    logic       NO_SLOT;
    logic       GAP_ERR;
    logic       RANGE_ERR;
    logic       GA_CHG;

    modport master (
        output GA_IN, GAP_IN, REACQ,
        input  GA_OUT, GA_VALID, NO_SLOT, GAP_ERR, RANGE_ERR, GA_CHG
    );

    modport slave (
        input  GA_IN, GAP_IN, REACQ,
        output GA_OUT, GA_VALID, NO_SLOT, GAP_ERR, RANGE_ERR, GA_CHG
    );

endinterface

// File: rtl/ga_sync2.sv
// Two-flop synchronizer for asynchronous level inputs; resets to all ones
// to match the pulled-up idle state of the backplane lines.
module ga_sync2 #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_d, meta_q;
    logic [W-1:0] sync_d, sync_q;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/ga_sampler.sv
// Geographical-address sampler: synchronizes GA/GAP, waits for a stable vector,
// classifies it and locks it. Define GA_SAMPLER_PARITY_CHK_EN to enable the GAP check.
module ga_sampler
    import ga_sampler_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 16
) (
    input  logic          CLK,
    input  logic          RST_n,
    ga_sampler_if.slave   bus
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

`ifdef GA_SAMPLER_PARITY_CHK_EN
    localparam logic [5:0] CMP_MASK = 6'h3F;
`else
    localparam logic [5:0] CMP_MASK = 6'h3E;
`endif
    localparam logic [5:0] PREV_RST = 6'h3F & CMP_MASK;

    logic [5:0] raw_vec, sync_vec, sync_m;
    logic       gap_bad, in_diff, lock_diff;

    logic [2:0] state_d, state_q;
    logic [7:0] cnt_d, cnt_q;
    logic [5:0] prev_d, prev_q;
    logic [4:0] ga_out_d, ga_out_q;
    logic       gap_lat_d, gap_lat_q;
    logic       valid_d, valid_q;
    logic       noslot_d, noslot_q;
    logic       gaperr_d, gaperr_q;
    logic       rangeerr_d, rangeerr_q;
    logic       chg_d, chg_q;

    assign raw_vec = {bus.GA_IN, bus.GAP_IN};

    ga_sync2 #(.W(6)) u_sync (
        .clk   (CLK),
        .rst_n (RST_n),
        .d     (raw_vec),
        .q     (sync_vec)
    );

    // With the parity check disabled the GAP bit is masked out of every compare.
    assign sync_m    = sync_vec & CMP_MASK;
    assign in_diff   = (sync_m != prev_q);
    assign lock_diff = (sync_m != ({ga_out_q, gap_lat_q} & CMP_MASK));

`ifdef GA_SAMPLER_PARITY_CHK_EN
    assign gap_bad = !parity_ok(sync_vec);
`else
    assign gap_bad = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        prev_d     = sync_m;
        ga_out_d   = ga_out_q;
        gap_lat_d  = gap_lat_q;
        valid_d    = valid_q;
        noslot_d   = noslot_q;
        gaperr_d   = gaperr_q;
        rangeerr_d = rangeerr_q;
        chg_d      = chg_q;

        if (bus.REACQ) begin
            state_d    = ST_SETTLE;
            cnt_d      = '0;
            valid_d    = 1'b0;
            noslot_d   = 1'b0;
            gaperr_d   = 1'b0;
            rangeerr_d = 1'b0;
            chg_d      = 1'b0;
        end else begin
            case (state_q)
                ST_SETTLE: begin
                    if (in_diff)
                        cnt_d = '0;
                    else if (cnt_q == CNT_MAX)
                        state_d = ST_CHECK;
                    else
                        cnt_d = cnt_q + 8'd1;
                end
                ST_CHECK: begin
                    cnt_d = '0;
                    if (sync_vec[5:1] == GA_NO_SLOT) begin
                        state_d  = ST_NOSLOT;
                        noslot_d = 1'b1;
                    end else if (gap_bad) begin
                        state_d  = ST_FAULT;
                        gaperr_d = 1'b1;
                    end else if (!in_slot_range(sync_vec[5:1])) begin
                        state_d    = ST_FAULT;
                        rangeerr_d = 1'b1;
                    end else begin
                        state_d   = ST_LOCKED;
                        ga_out_d  = sync_vec[5:1];
                        gap_lat_d = sync_vec[0];
                        valid_d   = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    // The settle counter is reused to time a sustained input change.
                    if (!chg_q) begin
                        if (!lock_diff)
                            cnt_d = '0;
                        else if (cnt_q == CNT_MAX)
                            chg_d = 1'b1;
                        else
                            cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_NOSLOT, ST_FAULT: begin
                end
                default: begin
                    state_d = ST_SETTLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q    <= ST_SETTLE;
            cnt_q      <= '0;
            prev_q     <= PREV_RST;
            ga_out_q   <= GA_NO_SLOT;
            gap_lat_q  <= 1'b1;
            valid_q    <= 1'b0;
            noslot_q   <= 1'b0;
            gaperr_q   <= 1'b0;
            rangeerr_q <= 1'b0;
            chg_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prev_q     <= prev_d;
            ga_out_q   <= ga_out_d;
            gap_lat_q  <= gap_lat_d;
            valid_q    <= valid_d;
            noslot_q   <= noslot_d;
            gaperr_q   <= gaperr_d;
            rangeerr_q <= rangeerr_d;
            chg_q      <= chg_d;
        end
    end

    assign bus.GA_OUT    = ga_out_q;
    assign bus.GA_VALID  = valid_q;
    assign bus.NO_SLOT   = noslot_q;
    assign bus.GAP_ERR   = gaperr_q;
    assign bus.RANGE_ERR = rangeerr_q;
    assign bus.GA_CHG    = chg_q;

endmodule

// File: tb/tb_ga_sampler.sv
// Directed self-checking bench for ga_sampler with hand-computed expectations.
module tb_ga_sampler;

    localparam int S = 16;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    ga_sampler_if bus();

    ga_sampler #(.STABLE_CYCLES(S)) dut (
        .CLK   (clk),
        .RST_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold reset two cycles with the new inputs applied, release at a falling edge.
    task automatic start(input logic [4:0] ga, input logic gap);
        @(negedge clk);
        rst_n      = 1'b0;
        bus.GA_IN  = ga;
        bus.GAP_IN = gap;
        bus.REACQ  = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    function automatic logic [4:0] flags();
        return {bus.GA_VALID, bus.NO_SLOT, bus.GAP_ERR, bus.RANGE_ERR, bus.GA_CHG};
    endfunction

    initial begin
        errors     = 0;
        checks     = 0;
        rst_n      = 1'b0;
        bus.GA_IN  = 5'h1F;
        bus.GAP_IN = 1'b1;
        bus.REACQ  = 1'b0;

        step(2);
        check("rst_ga_out", bus.GA_OUT, 5'h1F);
        check("rst_flags", flags(), 5'b00000);

        // Valid slot 30: lock exactly S+4 edges after release.
        start(5'h1E, 1'b1);
        step(S + 3);
        check("lat_early_valid", bus.GA_VALID, 1'b0);
        step(1);
        check("lat_valid", bus.GA_VALID, 1'b1);
        check("lat_ga_out", bus.GA_OUT, 5'h1E);
        check("lat_flags", flags(), 5'b10000);

        // Slot 30 with bad parity.
        start(5'h1E, 1'b0);
        step(S + 4);
`ifdef GA_SAMPLER_PARITY_CHK_EN
        check("gap_flags", flags(), 5'b00100);
`else
        check("gap_flags", flags(), 5'b10000);
        check("gap_ga_out", bus.GA_OUT, 5'h1E);
`endif

        // No slot present: valid must never rise.
        start(5'h1F, 1'b1);
        for (int i = 0; i < S + 8; i++) begin
            step(1);
            check("noslot_valid", bus.GA_VALID, 1'b0);
        end
        check("noslot_flags", flags(), 5'b01000);
        check("noslot_ga_out", bus.GA_OUT, 5'h1F);

        // GA below slot 1 with good parity.
        start(5'h05, 1'b1);
        step(S + 4);
        check("range_flags", flags(), 5'b00010);

        // Input toggling every 3 cycles never settles.
        start(5'h0A, 1'b1);
        for (int i = 0; i < 60; i++) begin
            if (i % 3 == 2)
                bus.GA_IN = (bus.GA_IN == 5'h0A) ? 5'h1E : 5'h0A;
            step(1);
            check("toggle_flags", flags(), 5'b00000);
        end

        // Lock at slot 0x0A, then move to 0x0B and hold.
        start(5'h0A, 1'b1);
        step(S + 4);
        check("chg_lock_valid", bus.GA_VALID, 1'b1);
        check("chg_lock_ga_out", bus.GA_OUT, 5'h0A);
        bus.GA_IN  = 5'h0B;
        bus.GAP_IN = 1'b0;
        step(S + 1);
        check("chg_early", bus.GA_CHG, 1'b0);
        step(1);
        check("chg_set", flags(), 5'b10001);
        check("chg_ga_out", bus.GA_OUT, 5'h0A);
        step(5);
        check("chg_sticky", flags(), 5'b10001);

        // REACQ clears flags, keeps GA_OUT, then relocks on the new code.
        bus.REACQ = 1'b1;
        step(1);
        bus.REACQ = 1'b0;
        check("reacq_flags", flags(), 5'b00000);
        check("reacq_ga_out", bus.GA_OUT, 5'h0A);
        step(S);
        check("reacq_early_valid", bus.GA_VALID, 1'b0);
        step(1);
        check("reacq_valid", bus.GA_VALID, 1'b1);
        check("reacq_ga_out_new", bus.GA_OUT, 5'h0B);

        // Asynchronous reset while locked, sampled well before the next rising edge.
        #2 rst_n = 1'b0;
        #1;
        check("async_ga_out", bus.GA_OUT, 5'h1F);
        check("async_flags", flags(), 5'b00000);
        step(1);
        rst_n = 1'b1;
        step(S + 4);
        check("post_rst_ga_out", bus.GA_OUT, 5'h0B);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ga_sampler.md
GA_SAMPLER -- requirements
Module: ga_sampler

Interface
REQ-001 Parameter STABLE_CYCLES, default 16, sets the number of consecutive clocks the synchronized GA/GAP vector must hold unchanged before it is evaluated (legal range 2..255).
REQ-002 CLK  input  1  system clock.
REQ-003 RST_n  input  1  asynchronous active-low reset.
REQ-004 GA_IN  input  5  raw backplane geographical address lines, asynchronous, pulled up (5'h1F when no slot is present).
REQ-005 GAP_IN  input  1  raw backplane geographical address parity line, asynchronous.
REQ-006 REACQ  input  1  single-cycle request to discard the current result and re-sample.
REQ-007 GA_OUT  output  5  validated GA code for the slot-to-BAR decoder; valid only while GA_VALID=1.
REQ-008 GA_VALID  output  1  GA_OUT holds a checked slot code (5'h0A..5'h1E).
REQ-009 NO_SLOT  output  1  stable GA of 5'h1F, meaning no slot is present.
REQ-010 GAP_ERR  output  1  stable GA/GAP vector failed the odd-parity check.
REQ-011 RANGE_ERR  output  1  stable GA in 5'h00..5'h09, which is outside slots 1..21.
REQ-012 GA_CHG  output  1  sticky flag: the input changed after lock.

Function
REQ-013 GA_IN and GAP_IN shall each pass through a two-flop synchronizer before any other logic uses them.
REQ-014 The FSM shall have five states, with transitions as follows.
- SETTLE to CHECK: the settle counter reaches STABLE_CYCLES-1.
- CHECK: lasts exactly one cycle.
- CHECK to LOCKED, NOSLOT or FAULT: per REQ-016.
- LOCKED, NOSLOT and FAULT: terminal until REACQ or reset.
REQ-015 In SETTLE, the counter shall clear to 0 on any cycle where the synchronized 6-bit vector differs from its value on the previous cycle, and shall otherwise increment, saturating at STABLE_CYCLES-1.
REQ-016 CHECK shall evaluate the stable vector in this priority order:
- GA=5'h1F: go to NOSLOT.
- Parity bad (the XOR of GA[4:0] and GAP is 0): go to FAULT and set GAP_ERR.
- GA<5'h0A: go to FAULT and set RANGE_ERR.
- Otherwise: go to LOCKED.
REQ-017 On entry to LOCKED, GA_OUT shall latch the stable GA and GA_VALID shall assert on the same edge.
REQ-018 GA_OUT shall not change while in LOCKED.
REQ-019 Latency: GA_VALID shall assert exactly STABLE_CYCLES+4 rising edges after the first edge that samples the final GA_IN/GAP_IN value.
REQ-020 In LOCKED, if the synchronized vector differs from the latched vector for STABLE_CYCLES consecutive cycles, GA_CHG shall set and remain set; GA_VALID and GA_OUT shall be unaffected.
REQ-021 REACQ asserted in any state shall, on the next edge:
- enter SETTLE;
- clear the counter;
- clear GA_VALID, NO_SLOT, GAP_ERR, RANGE_ERR and GA_CHG;
- leave GA_OUT holding its last value.
REQ-022 If REACQ is asserted on the same cycle CHECK would resolve, REACQ shall win.
REQ-023 NO_SLOT, GAP_ERR, RANGE_ERR and GA_VALID shall be mutually exclusive at all times.

Reset
REQ-024 RST_n low shall asynchronously force:
- the FSM to SETTLE and the counter to 0;
- the synchronizers to 6'h3F;
- GA_OUT to 5'h1F;
- all flags to 0.
REQ-025 Deassertion of RST_n shall be synchronized to CLK outside this block; the first active edge after release shall begin settling.
REQ-026 Reset asserted mid-settle or while LOCKED shall discard all state, with no partial result retained.

Configuration
REQ-027 Macro GA_SAMPLER_PARITY_CHK_EN defined: the parity check of REQ-016 shall be active.
REQ-028 Macro GA_SAMPLER_PARITY_CHK_EN undefined: the parity step shall be skipped, GAP_ERR shall be tied to 0, and GAP_IN shall be ignored (both by the synchronizer compare and by GA_CHG).

Structure
REQ-029 A shared package shall hold:
- the FSM state encoding;
- the constants GA_NO_SLOT=5'h1F, GA_MIN_SLOT=5'h0A and GA_MAX_SLOT=5'h1E.
REQ-030 The two-flop synchronizer shall be a separate sub-module, ga_sync2, instantiated once with a 6-bit vector width.

Verification
REQ-031 The bench shall cover these directed scenarios:
- Reset release with GA_IN=5'h1E, GAP_IN=1: GA_VALID=1 and GA_OUT=5'h1E at edge STABLE_CYCLES+4, other flags 0.
- GA_IN=5'h1E, GAP_IN=0 with the macro defined: GAP_ERR=1, GA_VALID=0. With the macro undefined: GA_VALID=1.
- GA_IN=5'h1F: NO_SLOT=1 and GA_VALID never asserts.
- GA_IN=5'h05, GAP_IN=1: RANGE_ERR=1. GA_IN toggling every 3 cycles: no flag ever asserts.
- Locked at 5'h0A, then GA_IN changed to 5'h0B and held: GA_CHG=1 after STABLE_CYCLES cycles, GA_OUT stays 5'h0A. A REACQ pulse then gives GA_OUT=5'h0B (with GAP_IN=0).
- RST_n pulsed low while LOCKED: all outputs reach their reset values immediately without waiting for a clock edge.
